// File: rtl/adder_serial_nbit_pkg.sv
// Shared definitions for the serial adder: FSM encoding and a width helper.
//   state_t    : IDLE / BUSY / DONE encodings of the top-level controller
//   clog2_min1 : ceil(log2(n)) clamped to at least 1, used to size the slice counter
package adder_serial_nbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for n states; a 1-state counter still needs one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_serial_nbit_if.sv
// Request/result bundle between a controller and the serial adder.
//   start, sub, A, B, Cin : request, sampled by the adder when idle
//   busy, done            : progress / one-cycle completion pulse
//   Sum, Cout, Ovf        : result, held until the next completion
// WIDTH must match the WIDTH parameter of the adder it connects to.
interface adder_serial_nbit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output start, sub, A, B, Cin,
        input  busy, done, Sum, Cout, Ovf
    );

    modport slave (
        input  start, sub, A, B, Cin,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/adder_digit.sv
// DIGIT-bit ripple-carry slice built from full_adder cells.
//   a, b, cin : slice operands and incoming carry
//   sum       : slice sum
//   cout      : carry out of the top bit
//   c_msb     : carry into the top bit (for overflow detection)
module adder_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    // Ripple chain: carry of bit i feeds bit i+1.
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
//   a, b, cin : addends and carry-in
//   s, cout   : sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_serial_nbit.sv
// Serial WIDTH-bit add/subtract unit processing one DIGIT-bit slice per clock,
// LSB slice first, through a single shared ripple slice.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : request (start/sub/A/B/Cin) in, busy/done/Sum/Cout/Ovf out
// Start is accepted only when idle; busy covers NUM_DIGITS cycles and done
// pulses one cycle later together with the new Sum/Cout/Ovf.
module adder_serial_nbit
    import adder_serial_nbit_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_serial_nbit_if.slave   bus
);
    localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
    localparam int unsigned CNT_W      = clog2_min1(NUM_DIGITS);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("adder_serial_nbit: WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    state_t           state_nxt;
    logic             load_c;
    logic             step_c;
    logic             last_c;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic             c_q;
    logic [CNT_W-1:0] idx;

    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic             d_cmsb;

    // Shared slice always works on the low DIGIT bits of the operand shifters.
    adder_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_sr[DIGIT-1:0]),
        .b     (b_sr[DIGIT-1:0]),
        .cin   (c_q),
        .sum   (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    assign last_c  = (idx == CNT_W'(NUM_DIGITS - 1));
    // New slice enters at the top; after NUM_DIGITS steps the word is aligned.
    assign sum_nxt = (sum_sr >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_BUSY;
                    load_c    = 1'b1;
                end
            end
            ST_BUSY: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand/result shifters, slice carry, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            c_q      <= 1'b0;
            idx      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.Sum  <= '0;
            bus.Cout <= 1'b0;
            bus.Ovf  <= 1'b0;
        end else begin
            if (load_c) begin
                // Subtract is A + ~B + ~Cin, so invert B and the borrow-in once here.
                a_sr   <= bus.A;
                b_sr   <= bus.B ^ {WIDTH{bus.sub}};
                c_q    <= bus.Cin ^ bus.sub;
                sum_sr <= '0;
                idx    <= '0;
            end else if (step_c) begin
                a_sr   <= a_sr >> DIGIT;
                b_sr   <= b_sr >> DIGIT;
                c_q    <= d_cout;
                sum_sr <= sum_nxt;
                if (last_c) begin
                    bus.Sum  <= sum_nxt;
                    bus.Cout <= d_cout;
                    bus.Ovf  <= d_cmsb ^ d_cout;
                end else begin
                    idx <= idx + CNT_W'(1);
                end
            end
            bus.busy <= (state_nxt == ST_BUSY);
            bus.done <= (state_nxt == ST_DONE);
        end
    end

endmodule
